// File: rtl/matmul_requant_stream.sv
// Requantization stage behind the batched MatMul: scales each signed
// accumulator by cfg_mult, applies a round-half-up right shift, saturates to
// DATA_WIDTH, and tags the stream with row/matrix boundaries and head index.
//
// Handshake: a beat transfers on valid & ready at a rising clock edge. A
// producer holds valid and data until ready is seen. The three pipeline stages
// advance together whenever the output register is empty or being drained, so
// in_ready is combinational from out_ready and the output valid bit.
module matmul_requant_stream #(
  parameter int ACC_WIDTH      = 24,
  parameter int DATA_WIDTH     = 8,
  parameter int MULT_WIDTH     = 16,
  parameter int SHIFT_WIDTH    = 5,
  parameter int MATMUL_NUM     = 12,
  parameter int OUTPUT_SHAPE_1 = 128,
  parameter int OUTPUT_SHAPE_2 = 128,
  localparam int HEAD_W = (MATMUL_NUM > 1) ? $clog2(MATMUL_NUM) : 1
) (
  input  logic                         clk_p,
  input  logic                         rst_p,
  input  logic                         cfg_load,
  input  logic [MULT_WIDTH-1:0]        cfg_mult,
  input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [ACC_WIDTH-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last_row,
  output logic                         out_last_mat,
  output logic [HEAD_W-1:0]            out_head_idx,
  output logic                         idle,
  output logic [15:0]                  sat_cnt
);

  localparam int P_W   = ACC_WIDTH + MULT_WIDTH + 1;
  localparam int R_W   = P_W + 1;
  localparam int ROW_W = (OUTPUT_SHAPE_1 > 1) ? $clog2(OUTPUT_SHAPE_1) : 1;
  localparam int COL_W = (OUTPUT_SHAPE_2 > 1) ? $clog2(OUTPUT_SHAPE_2) : 1;
  localparam logic signed [R_W-1:0] SAT_MAX = R_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [R_W-1:0] SAT_MIN = ~SAT_MAX;

  // Shadow configuration and saturation counter
  logic [MULT_WIDTH-1:0]  mult_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [15:0]            sat_q;

  // Pipeline registers
  logic                         v1_q, v2_q, out_valid_q;
  logic signed [P_W-1:0]        p1_q;
  logic signed [R_W-1:0]        r2_q;
  logic signed [DATA_WIDTH-1:0] out_data_q;

  // Output position counters
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [HEAD_W-1:0] head_q, head_d;

  logic                         adv, cfg_take;
  logic [MULT_WIDTH-1:0]        eff_mult;
  logic signed [P_W-1:0]        a_ext, m_ext, p_d;
  logic signed [R_W-1:0]        p_ext, rnd, sum, r_d;
  logic                         sat_hi, sat_lo;
  logic signed [DATA_WIDTH-1:0] clamp_d;
  logic                         last_col, last_row, last_head;

  assign adv      = out_ready | ~out_valid_q;
  assign in_ready = adv;
  assign idle     = ~v1_q & ~v2_q & ~out_valid_q &
                    (col_q == '0) & (row_q == '0) & (head_q == '0);
  assign cfg_take = cfg_load & idle;

  // A beat accepted on the same edge as a cfg load uses the new multiplier.
  assign eff_mult = cfg_take ? cfg_mult : mult_q;
  assign a_ext    = P_W'(in_data);
  assign m_ext    = P_W'($signed({1'b0, eff_mult}));
  assign p_d      = a_ext * m_ext;

  // One extra bit of headroom keeps the rounding add from overflowing.
  assign p_ext = R_W'(p1_q);
  assign rnd   = (shift_q == '0) ? '0 : (R_W'(1) << (shift_q - SHIFT_WIDTH'(1)));
  assign sum   = p_ext + rnd;
  assign r_d   = sum >>> shift_q;

  assign sat_hi  = r2_q > SAT_MAX;
  assign sat_lo  = r2_q < SAT_MIN;
  assign clamp_d = sat_hi ? SAT_MAX[DATA_WIDTH-1:0] :
                   sat_lo ? SAT_MIN[DATA_WIDTH-1:0] : r2_q[DATA_WIDTH-1:0];

  assign last_col  = (col_q == COL_W'(OUTPUT_SHAPE_2 - 1));
  assign last_row  = (row_q == ROW_W'(OUTPUT_SHAPE_1 - 1));
  assign last_head = (head_q == HEAD_W'(MATMUL_NUM - 1));

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last_row = last_col;
  assign out_last_mat = last_col & last_row;
  assign out_head_idx = head_q;
  assign sat_cnt      = sat_q;

  // Next output position, stepped only by an output handshake
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    head_d = head_q;
    if (out_valid_q & out_ready) begin
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d  = '0;
          head_d = last_head ? '0 : head_q + HEAD_W'(1);
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Shadow cfg load while idle; count saturated beats entering the output register
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      mult_q  <= '0;
      shift_q <= '0;
      sat_q   <= '0;
    end else if (cfg_take) begin
      mult_q  <= cfg_mult;
      shift_q <= cfg_shift;
      sat_q   <= '0;
    end else if (adv & v2_q & (sat_hi | sat_lo) & (sat_q != 16'hFFFF)) begin
      sat_q <= sat_q + 16'd1;
    end
  end

  // Three-stage multiply / round-shift / clamp pipeline with a shared advance
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      p1_q        <= '0;
      r2_q        <= '0;
      out_data_q  <= '0;
    end else if (adv) begin
      v1_q        <= in_valid;
      p1_q        <= p_d;
      v2_q        <= v1_q;
      r2_q        <= r_d;
      out_valid_q <= v2_q;
      if (v2_q) out_data_q <= clamp_d;
    end
  end

  // Output position registers
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      col_q  <= '0;
      row_q  <= '0;
      head_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      head_q <= head_d;
    end
  end

endmodule

// File: tb/tb_matmul_requant_stream.sv
// Bench for matmul_requant_stream with a reduced 2x3 shape and two heads.
// A reference model predicts every output element and its position tags.
module tb_matmul_requant_stream;

  localparam int NR  = 2;
  localparam int NC  = 3;
  localparam int NH  = 2;
  localparam int TOT = NR * NC * NH;

  logic              clk_p = 1'b0;
  logic              rst_p = 1'b1;
  logic              cfg_load = 1'b0;
  logic [15:0]       cfg_mult = '0;
  logic [4:0]        cfg_shift = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [23:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_data;
  logic              out_last_row, out_last_mat;
  logic [0:0]        out_head_idx;
  logic              idle;
  logic [15:0]       sat_cnt;

  matmul_requant_stream #(
    .ACC_WIDTH(24), .DATA_WIDTH(8), .MULT_WIDTH(16), .SHIFT_WIDTH(5),
    .MATMUL_NUM(NH), .OUTPUT_SHAPE_1(NR), .OUTPUT_SHAPE_2(NC)
  ) dut (
    .clk_p(clk_p), .rst_p(rst_p), .cfg_load(cfg_load), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last_row(out_last_row), .out_last_mat(out_last_mat),
    .out_head_idx(out_head_idx), .idle(idle), .sat_cnt(sat_cnt)
  );

  // Clock
  always #5 clk_p = ~clk_p;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [7:0]  exp_q[$];
  int          pos = 0;
  int unsigned m_mult = 0;
  int unsigned m_shift = 0;
  int          m_sat = 0;
  bit          hold_v = 0;
  logic [7:0]  hold_d = '0;
  bit          rnd_en = 0;

  // Log of accepted outputs for directed literal checks
  logic [7:0] log_d[$];
  bit         log_lr[$];
  bit         log_lm[$];
  int         log_h[$];

  function automatic void chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endfunction

  // Requantization rule: scale, round half up, saturate to int8
  function automatic logic [7:0] model_rq(input logic signed [23:0] d, input int unsigned m,
                                          input int unsigned s, output bit sat);
    longint p, r;
    p = longint'(d) * longint'(m);
    if (s == 0) r = p;
    else r = (p + (longint'(1) <<< (s - 1))) >>> s;
    sat = 0;
    if (r > 127) begin r = 127; sat = 1; end
    else if (r < -128) begin r = -128; sat = 1; end
    return 8'(r);
  endfunction

  // Compare process: checks the DUT against the model on every cycle
  task automatic run_monitor();
    bit s, m_idle;
    logic [7:0] e;
    forever begin
      @(negedge clk_p);
      if (rst_p) begin
        exp_q.delete();
        pos = 0; m_mult = 0; m_shift = 0; m_sat = 0; hold_v = 0;
      end else begin
        m_idle = (exp_q.size() == 0) && (pos == 0);
        chk("idle", idle, m_idle);
        if (hold_v) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", $signed(out_data), $signed(hold_d));
        end
        if (out_valid) begin
          chk("last_row", out_last_row, (pos % NC) == NC - 1);
          chk("last_mat", out_last_mat, ((pos % NC) == NC - 1) && (((pos / NC) % NR) == NR - 1));
          chk("head_idx", out_head_idx, pos / (NR * NC));
          if (exp_q.size() == 0) begin
            chk("spurious_valid", 1, 0);
          end else if (out_ready) begin
            e = exp_q.pop_front();
            chk("data", $signed(out_data), $signed(e));
            log_d.push_back(out_data);
            log_lr.push_back(out_last_row);
            log_lm.push_back(out_last_mat);
            log_h.push_back(int'(out_head_idx));
            pos = (pos + 1) % TOT;
          end
          hold_v = !out_ready;
          hold_d = out_data;
        end else begin
          hold_v = 0;
        end
        if (cfg_load && m_idle) begin
          m_mult = cfg_mult; m_shift = cfg_shift; m_sat = 0;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model_rq(in_data, m_mult, m_shift, s));
          if (s && m_sat != 65535) m_sat++;
        end
      end
    end
  endtask

  // Output backpressure driver
  task automatic run_ready();
    forever begin
      @(posedge clk_p); #1;
      out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic run_watchdog();
    #200000;
    $display("FAIL watchdog at %0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Driver tasks: all start and end 1 time unit after a rising edge
  task automatic send(input int d);
    int n = 0;
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = 24'(d);
    while (!ok && n < 100) begin
      @(negedge clk_p); ok = in_ready;
      @(posedge clk_p); #1; n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic do_cfg(input int m, input int s);
    cfg_load = 1'b1; cfg_mult = 16'(m); cfg_shift = 5'(s);
    @(posedge clk_p); #1;
    cfg_load = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk_p); n++;
    end
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    rst_p = 1'b1; in_valid = 1'b0; cfg_load = 1'b0;
    @(posedge clk_p); @(posedge clk_p); #1;
    rst_p = 1'b0;
    @(negedge clk_p);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_sat_cnt", sat_cnt, 0);
    @(posedge clk_p); #1;
  endtask

  logic [11:0] lr_exp = 12'b1001_0010_0100;
  logic [11:0] lm_exp = 12'b1000_0010_0000;
  logic [11:0] hd_exp = 12'b1111_1100_0000;

  initial begin
    int base;
    fork
      run_monitor();
      run_ready();
      run_watchdog();
    join_none

    // Reset state, then idle output stays zero with shadow mult of 0
    apply_reset();

    // 1: unity gain and three-cycle latency
    do_cfg(1, 0);
    base = log_d.size();
    send(100);
    @(negedge clk_p); chk("lat_c1", out_valid, 0);
    @(negedge clk_p); chk("lat_c2", out_valid, 0);
    @(negedge clk_p); chk("lat_c3", out_valid, 1);
    @(posedge clk_p); #1;
    drain();
    chk("t1_data", $signed(log_d[base]), 100);
    chk("t1_sat", sat_cnt, 0);

    // 2: round half up
    apply_reset();
    do_cfg(1, 1);
    base = log_d.size();
    send(5); send(-5); send(3); send(-3);
    drain();
    chk("rnd_5", $signed(log_d[base]), 3);
    chk("rnd_m5", $signed(log_d[base + 1]), -2);
    chk("rnd_3", $signed(log_d[base + 2]), 2);
    chk("rnd_m3", $signed(log_d[base + 3]), -1);

    // 3: saturation, then finish the batch so cfg_load clears the count
    apply_reset();
    do_cfg(16384, 15);
    base = log_d.size();
    send(1000); send(-1000);
    for (int k = 0; k < TOT - 2; k++) send(0);
    drain();
    @(negedge clk_p);
    chk("sat_hi", $signed(log_d[base]), 127);
    chk("sat_lo", $signed(log_d[base + 1]), -128);
    chk("sat_cnt_2", sat_cnt, 2);
    chk("sat_cnt_model", sat_cnt, m_sat);
    chk("idle_after_batch", idle, 1);
    @(posedge clk_p); #1;
    do_cfg(1, 0);
    @(negedge clk_p);
    chk("sat_cleared", sat_cnt, 0);
    @(posedge clk_p); #1;

    // 4: random backpressure, sequence must be exact
    apply_reset();
    do_cfg(1, 0);
    base = log_d.size();
    rnd_en = 1;
    for (int k = 0; k <= 20; k++) send(k);
    drain();
    rnd_en = 0;
    chk("bp_count", log_d.size() - base, 21);
    for (int k = 0; k <= 20; k++) chk("bp_seq", $signed(log_d[base + k]), k);

    // 5: boundary flags and head wrap over one full batch
    apply_reset();
    do_cfg(1, 0);
    base = log_d.size();
    for (int k = 1; k <= 13; k++) send(k);
    drain();
    for (int k = 0; k < 12; k++) begin
      chk("flag_last_row", log_lr[base + k], lr_exp[k]);
      chk("flag_last_mat", log_lm[base + k], lm_exp[k]);
      chk("flag_head", log_h[base + k], hd_exp[k]);
    end
    chk("wrap_head", log_h[base + 12], 0);
    chk("wrap_last_row", log_lr[base + 12], 0);

    // 6a: cfg_load mid-matrix is ignored
    apply_reset();
    do_cfg(1, 0);
    base = log_d.size();
    send(10); send(20); send(30); send(40);
    drain();
    do_cfg(2, 0);
    send(50); send(60);
    drain();
    chk("ign_cfg_a", $signed(log_d[base + 4]), 50);
    chk("ign_cfg_b", $signed(log_d[base + 5]), 60);

    // 6b: reset with two beats in flight
    send(70); send(80);
    rst_p = 1'b1;
    @(negedge clk_p);
    chk("flush_valid", out_valid, 0);
    @(posedge clk_p); #1;
    rst_p = 1'b0;
    @(posedge clk_p); #1;
    do_cfg(1, 0);
    base = log_d.size();
    send(90);
    drain();
    chk("post_rst_count", log_d.size() - base, 1);
    chk("post_rst_data", $signed(log_d[base]), 90);
    chk("post_rst_head", log_h[base], 0);
    chk("post_rst_lr", log_lr[base], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
